// File: rtl/hue_calc_pipe.sv
`default_nettype none
// ============================================================================
// Module   : hue_calc_pipe
// Purpose  : Four-stage streaming map from note position within an octave to
//            a hue on a 2^D colour wheel (piecewise-linear, three segments),
//            with a per-channel bank holding the latest hue of each slot.
// Revision : 1.0 - initial release
// ============================================================================
module hue_calc_pipe #(
  parameter int D         = 10,
  parameter int CHANNELS  = 8,
  parameter int HUE_START = 170,
  parameter int DELTA0    = -170,
  parameter int DELTA1    = -341,
  parameter int DELTA2    = -513,
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [D-1:0]          in_pos,
  input  logic [CW-1:0]         in_chan,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [D-1:0]          out_hue,
  output logic [CW-1:0]         out_chan,
  output logic                  out_last,
  output logic [CHANNELS*D-1:0] hues_o,
  output logic                  frame_done
);

  // Segment slopes at D+1 bits signed, anchors reduced mod 2^D at elaboration
  localparam logic signed [D:0] DELTA0_S = DELTA0[D:0];
  localparam logic signed [D:0] DELTA1_S = DELTA1[D:0];
  localparam logic signed [D:0] DELTA2_S = DELTA2[D:0];
  localparam int                A1_I     = HUE_START + DELTA0;
  localparam int                A2_I     = A1_I + DELTA1;
  localparam logic [D-1:0]      ANCHOR0  = HUE_START[D-1:0];
  localparam logic [D-1:0]      ANCHOR1  = A1_I[D-1:0];
  localparam logic [D-1:0]      ANCHOR2  = A2_I[D-1:0];

  // Stage valid bits and payload registers
  logic                  v1, v2, v3, v4;
  logic [D-1:0]          s1_pos;
  logic [CW-1:0]         s1_chan, s2_chan, s3_chan, s4_chan;
  logic                  s1_last, s2_last, s3_last, s4_last;
  logic [1:0]            s2_seg, s3_seg;
  logic [D-1:0]          s2_f;
  logic signed [2*D+1:0] s3_m;
  logic [D-1:0]          s4_hue;

  logic                  advance;
  logic                  out_fire;
  logic [D+1:0]          t3;
  logic signed [D:0]     sel_delta;
  logic signed [2*D+1:0] prod;
  logic [D-1:0]          sel_anchor;
  logic [D-1:0]          hue_next;
  logic                  m_unused;

  // Whole pipe moves as one; input is refused while the reset is held
  assign advance  = !v4 || out_ready;
  assign in_ready = advance && rst;
  assign out_fire = v4 && out_ready;

  // 3*pos spans exactly three octave-widths; top two bits pick the segment
  assign t3 = {2'b00, s1_pos} + {1'b0, s1_pos, 1'b0};

  // Both operands widened to the product width so the multiply is exact
  assign prod = {{(D+1){sel_delta[D]}}, sel_delta} * $signed({{(D+2){1'b0}}, s2_f});

  // Bits [2D-1:D] of m are the low D bits of the floored m >>> D
  assign hue_next = sel_anchor + s3_m[2*D-1:D];
  assign m_unused = ^{s3_m[2*D+1:2*D], s3_m[D-1:0]};

  // Slope for the segment currently in S2
  always_comb begin
    sel_delta = DELTA0_S;
    case (s2_seg)
      2'd1:    sel_delta = DELTA1_S;
      2'd2:    sel_delta = DELTA2_S;
      default: sel_delta = DELTA0_S;
    endcase
  end

  // Anchor hue for the segment currently in S3
  always_comb begin
    sel_anchor = ANCHOR0;
    case (s3_seg)
      2'd1:    sel_anchor = ANCHOR1;
      2'd2:    sel_anchor = ANCHOR2;
      default: sel_anchor = ANCHOR0;
    endcase
  end

  // Stage valid bits: cleared by reset, shifted together on advance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      v4 <= 1'b0;
    end else if (advance) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
      v4 <= v3;
    end
  end

  // Payload registers: no reset needed, qualified by the valid bits
  always_ff @(posedge clk) begin
    if (advance) begin
      s1_pos  <= in_pos;
      s1_chan <= in_chan;
      s1_last <= in_last;
      s2_seg  <= t3[D+1:D];
      s2_f    <= t3[D-1:0];
      s2_chan <= s1_chan;
      s2_last <= s1_last;
      s3_seg  <= s2_seg;
      s3_m    <= prod;
      s3_chan <= s2_chan;
      s3_last <= s2_last;
      s4_hue  <= hue_next;
      s4_chan <= s3_chan;
      s4_last <= s3_last;
    end
  end

  assign out_valid = v4;
  assign out_hue   = s4_hue;
  assign out_chan  = s4_chan;
  assign out_last  = s4_last;

  // Pulse one cycle after the handshake that closes a frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) frame_done <= 1'b0;
    else      frame_done <= out_fire && s4_last;
  end

  // One slot per channel; tags beyond CHANNELS-1 match no slot
  for (genvar c = 0; c < CHANNELS; c++) begin : g_bank
    localparam logic [CW-1:0] IDX = CW'(c);
    logic [D-1:0] slot;

    // Capture the hue delivered to this channel on its handshake
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                          slot <= '0;
      else if (out_fire && s4_chan == IDX) slot <= s4_hue;
    end

    assign hues_o[c*D +: D] = slot;
  end

endmodule
`default_nettype wire

// File: tb/tb_hue_calc_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_hue_calc_pipe
// Purpose  : Self-checking bench for hue_calc_pipe (8-slot and 6-slot copies)
// Revision : 1.0 - initial release
// ============================================================================
module tb_hue_calc_pipe;
  localparam int D   = 10;
  localparam int ONE = 1 << D;
  localparam int CW  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic [D-1:0] in_pos = '0;
  logic [CW-1:0] in_chan = '0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;

  logic ir8, ov8, ol8, fd8;
  logic [D-1:0] oh8;
  logic [CW-1:0] oc8;
  logic [8*D-1:0] hues8;
  logic ir6, ov6, ol6, fd6;
  logic [D-1:0] oh6;
  logic [CW-1:0] oc6;
  logic [6*D-1:0] hues6;

  always #5 clk = ~clk;

  hue_calc_pipe #(.D(D), .CHANNELS(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8), .in_pos(in_pos),
    .in_chan(in_chan), .in_last(in_last), .out_valid(ov8), .out_ready(out_ready),
    .out_hue(oh8), .out_chan(oc8), .out_last(ol8), .hues_o(hues8), .frame_done(fd8));

  hue_calc_pipe #(.D(D), .CHANNELS(6)) dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir6), .in_pos(in_pos),
    .in_chan(in_chan), .in_last(in_last), .out_valid(ov6), .out_ready(out_ready),
    .out_hue(oh6), .out_chan(oc6), .out_last(ol6), .hues_o(hues6), .frame_done(fd6));

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Hue from the octave position: which third of the octave, how far into
  // it, then anchor plus the floored fraction of that third's hue change.
  function automatic int model_hue(input int pos);
    int seg, f, delta, anchor, prod, q, h;
    seg    = (3 * pos) / ONE;
    f      = (3 * pos) - seg * ONE;
    delta  = (seg == 0) ? -170 : (seg == 1) ? -341 : -513;
    anchor = (seg == 0) ? 170 : (seg == 1) ? (170 - 170) : (170 - 170 - 341);
    prod   = delta * f;
    q      = (prod >= 0) ? prod / ONE : -((-prod + ONE - 1) / ONE);
    h      = (anchor + q) % ONE;
    if (h < 0) h += ONE;
    return h;
  endfunction

  function automatic logic [127:0] pack_bank(input int b[8], input int n);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < n; c++) r[c*D +: D] = b[c][D-1:0];
    return r;
  endfunction

  typedef struct {
    int hue;
    int chan;
    bit last;
  } exp_t;

  exp_t q[$];
  exp_t front;
  exp_t nw;
  int   bank8[8];
  int   bank6[8];
  bit   fd_pend;
  bit   hs;

  // Scoreboard: every negedge compares outputs, bank and frame pulse to the model
  always @(negedge clk) begin
    if (!rst) begin
      check("rst_out_valid8", ov8, 0);
      check("rst_out_valid6", ov6, 0);
      check("rst_in_ready", ir8, 0);
      check("rst_frame_done", fd8, 0);
      check("rst_hues8", hues8, 0);
      check("rst_hues6", hues6, 0);
      q.delete();
      for (int c = 0; c < 8; c++) begin
        bank8[c] = 0;
        bank6[c] = 0;
      end
      fd_pend = 1'b0;
    end else begin
      check("frame_done8", fd8, fd_pend);
      check("frame_done6", fd6, fd_pend);
      check("hues8", hues8, pack_bank(bank8, 8));
      check("hues6", hues6, pack_bank(bank6, 6));
      check("in_ready", ir8, (!ov8 || out_ready));
      hs = 1'b0;
      if (ov8 || ov6) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", 1, 0);
        end else begin
          front = q[0];
          check("out_valid8", ov8, 1);
          check("out_valid6", ov6, 1);
          check("out_hue8", oh8, front.hue);
          check("out_chan8", oc8, front.chan);
          check("out_last8", ol8, front.last);
          check("out_hue6", oh6, front.hue);
          check("out_chan6", oc6, front.chan);
          check("out_last6", ol6, front.last);
          hs = out_ready;
        end
      end
      fd_pend = hs && front.last;
      if (hs) begin
        bank8[front.chan] = front.hue;
        if (front.chan < 6) bank6[front.chan] = front.hue;
        void'(q.pop_front());
      end
      if (in_valid && ir8) begin
        nw.hue  = model_hue(int'(in_pos));
        nw.chan = int'(in_chan);
        nw.last = in_last;
        q.push_back(nw);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int pos, input int chan, input bit last);
    in_valid = 1'b1;
    in_pos   = pos[D-1:0];
    in_chan  = chan[CW-1:0];
    in_last  = last;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1);
  end

  int pos_s1[6]  = '{0, 341, 342, 512, 683, 1023};
  int hue_s1[6]  = '{170, 0, 1023, 853, 682, 171};
  logic [D-1:0]   held_hue;
  logic [CW-1:0]  held_chan;
  logic [6*D-1:0] hues6_before;
  int fd_count;

  initial begin
    // Model pins
    check("model_pos0", model_hue(0), 170);
    check("model_pos512", model_hue(512), 853);
    check("model_pos1023", model_hue(1023), 171);

    // Reset and release
    tick(); tick();
    check("in_ready_in_reset", ir8, 0);
    rst = 1'b1;
    #1;
    check("in_ready_after_release", ir8, 1);

    // Continuous stream, results three edges after acceptance
    for (int i = 0; i < 6; i++) begin
      drive(pos_s1[i], i, 1'b0);
      check("s1_in_ready", ir8, 1);
      tick();
      check("s1_out_valid", ov8, (i >= 3));
      if (i >= 3) check("s1_hue", oh8, hue_s1[i-3]);
    end
    in_valid = 1'b0;
    for (int i = 6; i < 9; i++) begin
      tick();
      check("s1_out_valid_tail", ov8, 1);
      check("s1_hue_tail", oh8, hue_s1[i-3]);
    end
    tick(); tick();
    for (int c = 0; c < 6; c++) check("s1_bank", hues8[c*D +: D], hue_s1[c]);
    check("s1_bank6", hues8[6*D +: D], 0);
    check("s1_bank7", hues8[7*D +: D], 0);

    // Backpressure with four notes in flight
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(50 + 250 * i, i, 1'b0);
      tick();
    end
    drive(900, 5, 1'b0);
    held_hue  = oh8;
    held_chan = oc8;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", ir8, 0);
      check("bp_hue_stable", oh8, held_hue);
      check("bp_chan_stable", oc8, held_chan);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("bp_drained", q.size(), 0);

    // Overwrite channel 0
    drive(512, 0, 1'b0);
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    check("bank_ch0_overwrite", hues8[0 +: D], 853);

    // Frame marker on the third note
    fd_count = 0;
    drive(100, 1, 1'b0); tick();
    drive(200, 2, 1'b0); tick();
    drive(300, 3, 1'b1); tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (fd8) fd_count++;
      tick();
    end
    check("frame_done_count", fd_count, 1);

    // Out-of-range tag on the 6-slot copy
    hues6_before = hues6;
    drive(512, 7, 1'b0);
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("oor_out_hue", oh6, 853);
    check("oor_out_chan", oc6, 7);
    tick(); tick();
    check("oor_hues6_unchanged", hues6, hues6_before);

    // Reset mid-flight
    drive(10, 1, 1'b0); tick();
    drive(20, 2, 1'b0); tick();
    drive(30, 3, 1'b0); tick();
    in_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("mid_rst_out_valid", ov8, 0);
    check("mid_rst_hues8", hues8, 0);
    check("mid_rst_hues6", hues6, 0);
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_no_stale", ov8, 0);
    end
    drive(683, 2, 1'b0);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("post_rst_latency", ov8, 0);
    tick();
    check("post_rst_valid", ov8, 1);
    check("post_rst_hue", oh8, 682);
    for (int i = 0; i < 4; i++) tick();
    check("final_drained", q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
